ram_result_reader: RTL and testbench

- Read-back engine for the dual-port result RAM that the ROM/ALU controller fills with result pairs at addresses (2k, 2k+1).
- On a start pulse it reads NUM_PAIRS pairs through both RAM read ports, one pair per cycle.
- It presents each pair as one beat on a valid/ready output stream.
- A 3-entry buffer absorbs RAM read latency and downstream backpressure.

---
 rtl/ram_reader_pkg.sv | 19 +
 rtl/reader_fifo.sv | 56 +++++
 rtl/ram_result_reader.sv | 133 +++++++++++++
 tb/tb_ram_result_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared types and constants for the result RAM reader.
// No ports. Holds the FSM state encoding, the buffer depth and the beat width helper.
package ram_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int BUF_DEPTH = 3;
   localparam int CNT_W     = 2;

   function automatic int beat_w(input int bw);
      return 2 * bw;
   endfunction

endpackage

// File: rtl/reader_fifo.sv
// reader_fifo: 3-entry FIFO carrying one beat of data plus a last sideband bit.
// Ports: clk, rst (async active-low), push/push_data/push_last, pop, count, head_data/head_last.
module reader_fifo
   import ram_reader_pkg::*;
#(
   parameter int DW = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [DW-1:0]    push_data,
   input  logic             push_last,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output logic [DW-1:0]    head_data,
   output logic             head_last
);

   logic [DW:0]      mem [BUF_DEPTH];
   logic [CNT_W-1:0] rd_ptr;
   logic [CNT_W-1:0] wr_ptr;
   logic             pop_ok;
   logic             push_ok;

   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] p);
      return (p == CNT_W'(BUF_DEPTH - 1)) ? '0 : p + CNT_W'(1);
   endfunction

   assign pop_ok  = pop && (count != '0);
   // a full buffer may still accept a push when the head leaves this cycle
   assign push_ok = push && ((count != CNT_W'(BUF_DEPTH)) || pop_ok);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {push_last, push_data};
            wr_ptr      <= inc(wr_ptr);
         end
         if (pop_ok)
            rd_ptr <= inc(rd_ptr);
         if (push_ok && !pop_ok)
            count <= count + CNT_W'(1);
         else if (pop_ok && !push_ok)
            count <= count - CNT_W'(1);
      end
   end

   assign {head_last, head_data} = mem[rd_ptr];

endmodule

// File: rtl/ram_result_reader.sv
// ram_result_reader: reads NUM_PAIRS word pairs from a dual-port result RAM and streams
// them out as {qb,qa} beats. Ports: clk, rst (async active-low), start/base_addr,
// busy/done, ram_re/ram_addra/ram_addrb/ram_qa/ram_qb, out_valid/out_ready/out_data/out_last.
// Option macro READ_CHECKSUM_EN adds a checksum output (sum of qa+qb over sent beats).
module ram_result_reader
   import ram_reader_pkg::*;
#(
   parameter int BITWIDTH  = 8,
   parameter int ADDRWIDTH = 4,
   parameter int NUM_PAIRS = 8
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDRWIDTH-1:0]         base_addr,
   output logic                         busy,
   output logic                         done,
   output logic                         ram_re,
   output logic [ADDRWIDTH-1:0]         ram_addra,
   output logic [ADDRWIDTH-1:0]         ram_addrb,
   input  logic [BITWIDTH-1:0]          ram_qa,
   input  logic [BITWIDTH-1:0]          ram_qb,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [beat_w(BITWIDTH)-1:0]  out_data,
   output logic                         out_last
`ifdef READ_CHECKSUM_EN
   ,
   output logic [BITWIDTH-1:0]          checksum
`endif
);

   localparam int BW2 = beat_w(BITWIDTH);
   localparam logic [ADDRWIDTH-1:0] LAST_IDX = ADDRWIDTH'(NUM_PAIRS - 1);

   state_t               state;
   state_t               state_nxt;
   logic [ADDRWIDTH-1:0] base_reg;
   logic [ADDRWIDTH-1:0] issue_cnt;
   logic [ADDRWIDTH-1:0] beat_cnt;
   logic [ADDRWIDTH-1:0] raw_addr;
   logic                 rd_pend;
   logic                 rd_last;
   logic                 last_issue;
   logic                 accept;
   logic                 xfer;
   logic [CNT_W-1:0]     fifo_count;

   assign accept     = (state == IDLE) && start;
   assign last_issue = (issue_cnt == LAST_IDX);
   assign out_valid  = (fifo_count != '0);
   assign xfer       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (ram_re && last_issue) state_nxt = DRAIN;
         DRAIN:   if (xfer && (beat_cnt == LAST_IDX)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // issue only from registered occupancy so out_ready never reaches ram_re
   always_comb begin
      busy   = (state != IDLE);
      done   = (state == DONE);
      ram_re = (state == RUN) &&
               (({1'b0, fifo_count} + {2'b00, rd_pend}) < 3'(BUF_DEPTH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_reg  <= '0;
         issue_cnt <= '0;
         beat_cnt  <= '0;
         rd_pend   <= 1'b0;
         rd_last   <= 1'b0;
      end else begin
         rd_pend <= ram_re;
         rd_last <= ram_re && last_issue;
         if (accept) begin
            base_reg  <= base_addr;
            issue_cnt <= '0;
            beat_cnt  <= '0;
         end else begin
            if (ram_re)
               issue_cnt <= issue_cnt + ADDRWIDTH'(1);
            if (xfer)
               beat_cnt <= beat_cnt + ADDRWIDTH'(1);
         end
      end
   end

   // address wraps naturally through the ADDRWIDTH-bit add
   assign raw_addr  = base_reg + {issue_cnt[ADDRWIDTH-2:0], 1'b0};
   assign ram_addra = ram_re ? raw_addr : '0;
   assign ram_addrb = ram_re ? raw_addr + ADDRWIDTH'(1) : '0;

   reader_fifo #(
      .DW(BW2)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pend),
      .push_data ({ram_qb, ram_qa}),
      .push_last (rd_last),
      .pop       (xfer),
      .count     (fifo_count),
      .head_data (out_data),
      .head_last (out_last)
   );

`ifdef READ_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         checksum <= '0;
      else if (accept)
         checksum <= '0;
      else if (xfer)
         checksum <= checksum + out_data[BITWIDTH-1:0] + out_data[BW2-1:BITWIDTH];
   end
`endif

endmodule

// File: tb/tb_ram_result_reader.sv
// tb_ram_result_reader: randomized scoreboard bench for ram_result_reader.
// Models the result RAM and predicts every read address and beat from the RAM contents.
module tb_ram_result_reader;

   localparam int BW    = 8;
   localparam int AW    = 4;
   localparam int NP    = 8;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic [2*BW-1:0] data;
      logic            last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic            busy;
   logic            done;
   logic            ram_re;
   logic [AW-1:0]   ram_addra;
   logic [AW-1:0]   ram_addrb;
   logic [BW-1:0]   ram_qa = '0;
   logic [BW-1:0]   ram_qb = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [2*BW-1:0] out_data;
   logic            out_last;
`ifdef READ_CHECKSUM_EN
   logic [BW-1:0]   checksum;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int re_cnt = 0;
   int first_re = -1;
   int first_x = -1;
   int last_x = -1;
   int nx = 0;
   int start_cyc = 0;
   int ready_mode = 0;

   logic [BW-1:0] mem [DEPTH];
   logic [BW-1:0] sum_exp;
   beat_t         exp_q[$];
   logic [AW-1:0] addr_q[$];

   ram_result_reader #(
      .BITWIDTH (BW),
      .ADDRWIDTH(AW),
      .NUM_PAIRS(NP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base_addr(base_addr),
      .busy     (busy),
      .done     (done),
      .ram_re   (ram_re),
      .ram_addra(ram_addra),
      .ram_addrb(ram_addrb),
      .ram_qa   (ram_qa),
      .ram_qb   (ram_qb),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
`ifdef READ_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk)
      if (ram_re) begin
         ram_qa <= mem[ram_addra];
         ram_qb <= mem[ram_addrb];
      end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: pops predicted addresses and beats whenever the DUT presents them
   logic            held_v = 1'b0;
   logic [2*BW-1:0] held_d;
   logic            held_l;
   logic            done_prev = 1'b0;
   beat_t           e;
   logic [AW-1:0]   a;

   always @(negedge clk) begin
      if (rst) begin
         if (ram_re) begin
            re_cnt++;
            if (first_re < 0) first_re = cyc;
            if (addr_q.size() == 0)
               chk("unexpected_read", 1, 0);
            else begin
               a = addr_q.pop_front();
               chk("ram_addra", 32'(ram_addra), 32'(a));
               chk("ram_addrb", 32'(ram_addrb), 32'(AW'(a + 1'b1)));
            end
         end
         if (held_v) begin
            chk("valid_held", 32'(out_valid), 1);
            chk("stable_data", 32'(out_data), 32'(held_d));
            chk("stable_last", 32'(out_last), 32'(held_l));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
               chk("unexpected_beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_last", 32'(out_last), 32'(e.last));
            end
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            nx++;
         end
         if (done) begin
            chk("done_after_last", cyc, last_x + 1);
            chk("done_single", 32'(done_prev), 0);
         end
         held_v    = out_valid && !out_ready;
         held_d    = out_data;
         held_l    = out_last;
         done_prev = done;
      end else begin
         held_v    = 1'b0;
         done_prev = 1'b0;
      end
   end

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < DEPTH; i++)
         mem[i] = rnd ? BW'($urandom) : BW'(i + 1);
   endtask

   task automatic launch(input logic [AW-1:0] b);
      logic [AW-1:0] ad;
      sum_exp = '0;
      for (int k = 0; k < NP; k++) begin
         ad = AW'(b + AW'(2 * k));
         addr_q.push_back(ad);
         exp_q.push_back('{data: {mem[AW'(ad + 1'b1)], mem[ad]}, last: (k == NP - 1)});
         sum_exp = sum_exp + mem[ad] + mem[AW'(ad + 1'b1)];
      end
      first_x  = -1;
      last_x   = -1;
      first_re = -1;
      nx       = 0;
      re_cnt   = 0;
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = b;
      start_cyc = cyc + 1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      base_addr = AW'($urandom_range(0, 7) * 2);
   endtask

   task automatic wait_done(input string name, input bit poke);
      bit seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(negedge clk);
         if (n == 0) chk({name, "_busy"}, 32'(busy), 1);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         chk({name, "_timeout"}, 0, 1);
         return;
      end
`ifdef READ_CHECKSUM_EN
      chk({name, "_checksum"}, 32'(checksum), 32'(sum_exp));
`endif
      if (poke) begin
         start     = 1'b1;
         base_addr = 4'd4;
      end
      @(negedge clk);
      start = 1'b0;
      chk({name, "_busy_after"}, 32'(busy), 0);
      @(negedge clk);
      chk({name, "_idle_busy"}, 32'(busy), 0);
      chk({name, "_idle_re"}, 32'(ram_re), 0);
      chk({name, "_beats"}, nx, NP);
      chk({name, "_beats_left"}, exp_q.size(), 0);
      chk({name, "_reads_left"}, addr_q.size(), 0);
   endtask

   task automatic reset_outputs(input string name);
      chk({name, "_busy"}, 32'(busy), 0);
      chk({name, "_done"}, 32'(done), 0);
      chk({name, "_re"}, 32'(ram_re), 0);
      chk({name, "_addra"}, 32'(ram_addra), 0);
      chk({name, "_addrb"}, 32'(ram_addrb), 0);
      chk({name, "_valid"}, 32'(out_valid), 0);
      chk({name, "_data"}, 32'(out_data), 0);
      chk({name, "_last"}, 32'(out_last), 0);
`ifdef READ_CHECKSUM_EN
      chk({name, "_checksum"}, 32'(checksum), 0);
`endif
   endtask

   initial begin
      bit ok;
      fill_mem(1'b0);
      #3;
      reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // basic run, full rate
      ready_mode = 0;
      launch(4'd0);
      wait_done("basic", 1'b0);
      chk("basic_re_latency", first_re, start_cyc);
      chk("basic_valid_latency", first_x, start_cyc + 2);
      chk("basic_burst_len", last_x - first_x, NP - 1);

      // long stall: only the buffer depth worth of reads goes out
      ready_mode = 2;
      launch(4'd0);
      repeat (10) @(negedge clk);
      chk("stall_reads", re_cnt, 3);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_head", 32'(out_data), 32'h0201);
      ready_mode = 0;
      wait_done("stall", 1'b0);

      // wrap past the top of the RAM, plus a start during DONE
      launch(4'd14);
      wait_done("wrap", 1'b1);

      // random data and backpressure, with a start mid-run in one of them
      ready_mode = 1;
      for (int r = 0; r < 5; r++) begin
         fill_mem(1'b1);
         launch(AW'($urandom_range(0, 7) * 2));
         if (r == 2) begin
            repeat (3) @(posedge clk);
            #1;
            start     = 1'b1;
            base_addr = 4'd6;
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         wait_done($sformatf("rand%0d", r), 1'b0);
      end

      // reset while draining
      ready_mode = 0;
      fill_mem(1'b1);
      launch(4'd2);
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         if (re_cnt == NP) ok = 1'b1;
      end
      chk("drain_reached", 32'(ok), 1);
      ready_mode = 2;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      reset_outputs("midreset");
      exp_q.delete();
      addr_q.delete();
      repeat (2) @(negedge clk);
      reset_outputs("midreset_hold");
      rst = 1'b1;
      ready_mode = 1;
      fill_mem(1'b1);
      launch(4'd8);
      wait_done("after_reset", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
